// File: rtl/power_sequencer_if.sv
`default_nettype none
// ============================================================================
// power_sequencer_if : power_state/key_activity in, enable/LED/status out
// Revision 1.0 - initial release
// ============================================================================
interface power_sequencer_if;
    logic       power_state;
    logic       key_activity;
    logic       sys_en;
    logic       led_out;
    logic [1:0] seq_state;
    logic       auto_off;

    modport master (
        output power_state, key_activity,
        input  sys_en, led_out, seq_state, auto_off
    );

    modport slave (
        input  power_state, key_activity,
        output sys_en, led_out, seq_state, auto_off
    );
endinterface
`default_nettype wire

// File: rtl/power_sequencer.sv
`default_nettype none
// ============================================================================
// power_sequencer : staged sys_en and status LED from the power_state level.
// Optional idle auto-off request enabled by macro IDLE_TIMEOUT_EN.
// Revision 1.0 - initial release
// ============================================================================
module power_sequencer #(
    parameter int unsigned STARTUP_CYCLES  = 100_000_000,
    parameter int unsigned SHUTDOWN_CYCLES = 50_000_000,
    parameter int unsigned BLINK_HALF      = 12_500_000,
    parameter int unsigned IDLE_CYCLES     = 1_000_000_000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    power_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_STARTUP  = 2'd1,
        S_ON       = 2'd2,
        S_SHUTDOWN = 2'd3
    } state_t;

    localparam logic [31:0] c_START_LAST = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] c_SHUT_LAST  = 32'(SHUTDOWN_CYCLES - 1);
    localparam logic [31:0] c_BLINK_LAST = 32'(BLINK_HALF - 1);
    localparam logic [31:0] c_FAST_LAST  = 32'(BLINK_HALF / 2 - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_blink;
    logic        r_sys_en;
    logic        r_led;

    // Outputs are loaded with their next-state values so they are valid on the entry cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_OFF;
            r_cnt    <= '0;
            r_blink  <= '0;
            r_sys_en <= 1'b0;
            r_led    <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (bus.power_state) begin
                        r_state <= S_STARTUP;
                        r_cnt   <= '0;
                        r_blink <= '0;
                        r_led   <= 1'b1;
                    end
                end
                S_STARTUP: begin
                    if (!bus.power_state) begin
                        r_state <= S_OFF;
                        r_cnt   <= '0;
                        r_blink <= '0;
                        r_led   <= 1'b0;
                    end else if (r_cnt == c_START_LAST) begin
                        r_state  <= S_ON;
                        r_cnt    <= '0;
                        r_blink  <= '0;
                        r_sys_en <= 1'b1;
                        r_led    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (r_blink == c_BLINK_LAST) begin
                            r_blink <= '0;
                            r_led   <= ~r_led;
                        end else begin
                            r_blink <= r_blink + 32'd1;
                        end
                    end
                end
                S_ON: begin
                    if (!bus.power_state) begin
                        r_state  <= S_SHUTDOWN;
                        r_cnt    <= '0;
                        r_blink  <= '0;
                        r_sys_en <= 1'b0;
                        r_led    <= 1'b1;
                    end
                end
                S_SHUTDOWN: begin
                    // power_state is deliberately not looked at: shutdown always runs to completion.
                    if (r_cnt == c_SHUT_LAST) begin
                        r_state <= S_OFF;
                        r_cnt   <= '0;
                        r_blink <= '0;
                        r_led   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (r_blink == c_FAST_LAST) begin
                            r_blink <= '0;
                            r_led   <= ~r_led;
                        end else begin
                            r_blink <= r_blink + 32'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_OFF;
                    r_cnt    <= '0;
                    r_blink  <= '0;
                    r_sys_en <= 1'b0;
                    r_led    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sys_en    = r_sys_en;
    assign bus.led_out   = r_led;
    assign bus.seq_state = r_state;

`ifdef IDLE_TIMEOUT_EN
    localparam logic [31:0] c_IDLE_LAST = 32'(IDLE_CYCLES - 1);
    localparam logic [31:0] c_IDLE_HOLD = 32'(IDLE_CYCLES);

    logic [31:0] r_idle;
    logic        r_auto_off;

    // Counter parks one past the terminal value so the request fires only once per idle period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle     <= '0;
            r_auto_off <= 1'b0;
        end else if (r_state != S_ON) begin
            r_idle     <= '0;
            r_auto_off <= 1'b0;
        end else begin
            r_auto_off <= (r_idle == c_IDLE_LAST) && !bus.key_activity;
            if (bus.key_activity) begin
                r_idle <= '0;
            end else if (r_idle != c_IDLE_HOLD) begin
                r_idle <= r_idle + 32'd1;
            end
        end
    end

    assign bus.auto_off = r_auto_off;
`else
    logic w_unused_idle;
    assign w_unused_idle = ^{bus.key_activity, 32'(IDLE_CYCLES)};
    assign bus.auto_off  = 1'b0;
`endif

endmodule
`default_nettype wire
